// File: rtl/ppu_ctrl_pkg.sv
// Shared decode definitions for the PPU control pipe: opcodes, ALU/source
// encodings, and the 23-bit per-stage control bundle.
package ppu_ctrl_pkg;

  localparam int CTRL_W = 23;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_LUI = 4'd3,
    ALU_EQ  = 4'd4,
    ALU_GTZ = 4'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_IMM   = 3'd1,
    SRC_REG   = 3'd2,
    SRC_UPPER = 3'd3,
    SRC_PC    = 3'd4
  } src_op_e;

  typedef struct packed {
    src_op_e    src_op;
    alu_op_e    alu_op;
    logic       load;
    logic       rf_en;
    logic       branch;
    logic       jump;
    logic [1:0] mem_size;
    logic       mem_rw;
    logic       mem_se;
    logic       hi_en;
    logic       lo_en;
    logic       mem_en;
    logic [4:0] dest;
  } ctrl_t;

  // True when the instruction sources a register through its rt field.
  function automatic logic reads_rt(input logic [31:0] instr);
    logic [5:0] op;
    op = instr[31:26];
    return ((op == OP_RTYPE) && (instr[5:0] != FN_JR)) ||
           (op == OP_SB) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/ppu_control_pipe_if.sv
// ID-side inputs and per-stage control outputs of the PPU control pipe.
interface ppu_control_pipe_if
  import ppu_ctrl_pkg::*;
#(
  parameter int SAT_W = 16
);
  logic [31:0]      instruction;
  logic             instr_valid;
  logic             stall_in;
  logic             flush;
  ctrl_t            id_ctrl;
  ctrl_t            ex_ctrl;
  ctrl_t            mem_ctrl;
  ctrl_t            wb_ctrl;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             hazard_stall;
  logic             illegal_instr;
  logic [SAT_W-1:0] bubble_count;

  modport master (
    output instruction, instr_valid, stall_in, flush,
    input  id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
           hazard_stall, illegal_instr, bubble_count
  );

  modport slave (
    input  instruction, instr_valid, stall_in, flush,
    output id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl, ex_valid, mem_valid, wb_valid,
           hazard_stall, illegal_instr, bubble_count
  );
endinterface

// File: rtl/ppu_ctrl_decode.sv
// Combinational instruction decoder: unknown encodings give an all-zero bundle
// and flag illegal, except the all-zero NOP which is silently accepted.
module ppu_ctrl_decode
  import ppu_ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       miss;
  logic       unused_bits;

  assign op = instruction[31:26];
  assign rt = instruction[20:16];
  assign rd = instruction[15:11];
  assign fn = instruction[5:0];
  assign unused_bits = ^{instruction[25:21], instruction[10:6]};

  always_comb begin
    ctrl = '0;
    miss = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU: begin
            ctrl.src_op = SRC_REG;
            ctrl.alu_op = ALU_ADD;
            ctrl.rf_en  = 1'b1;
            ctrl.dest   = rd;
          end
          FN_SUBU: begin
            ctrl.src_op = SRC_REG;
            ctrl.alu_op = ALU_SUB;
            ctrl.rf_en  = 1'b1;
            ctrl.dest   = rd;
          end
          FN_JR: begin
            ctrl.src_op = SRC_REG;
            ctrl.jump   = 1'b1;
            ctrl.dest   = rd;
          end
          default: miss = 1'b1;
        endcase
      end
      OP_ADDIU: begin
        ctrl.src_op = SRC_IMM;
        ctrl.alu_op = ALU_ADD;
        ctrl.rf_en  = 1'b1;
        ctrl.dest   = rt;
      end
      OP_LUI: begin
        ctrl.src_op = SRC_UPPER;
        ctrl.alu_op = ALU_LUI;
        ctrl.rf_en  = 1'b1;
        ctrl.dest   = rt;
      end
      OP_LB, OP_LBU, OP_LW: begin
        ctrl.src_op   = SRC_IMM;
        ctrl.alu_op   = ALU_ADD;
        ctrl.load     = 1'b1;
        ctrl.rf_en    = 1'b1;
        ctrl.mem_en   = 1'b1;
        ctrl.mem_size = (op == OP_LW) ? SIZE_WORD : SIZE_BYTE;
        ctrl.mem_se   = (op == OP_LB);
        ctrl.dest     = rt;
      end
      OP_SB, OP_SW: begin
        ctrl.src_op   = SRC_IMM;
        ctrl.alu_op   = ALU_ADD;
        ctrl.mem_rw   = 1'b1;
        ctrl.mem_en   = 1'b1;
        ctrl.mem_size = (op == OP_SW) ? SIZE_WORD : SIZE_BYTE;
        ctrl.dest     = rt;
      end
      OP_BEQ: begin
        ctrl.src_op = SRC_REG;
        ctrl.alu_op = ALU_EQ;
        ctrl.branch = 1'b1;
        ctrl.dest   = rt;
      end
      OP_BGTZ: begin
        ctrl.src_op = SRC_REG;
        ctrl.alu_op = ALU_GTZ;
        ctrl.branch = 1'b1;
        ctrl.dest   = rt;
      end
      OP_JAL: begin
        ctrl.src_op = SRC_PC;
        ctrl.alu_op = ALU_ADD;
        ctrl.jump   = 1'b1;
        ctrl.rf_en  = 1'b1;
        ctrl.dest   = 5'd31;
      end
      default: miss = 1'b1;
    endcase
    illegal = miss && (instruction != 32'd0);
  end

endmodule

// File: rtl/ppu_control_pipe.sv
// EX/MEM/WB control-bundle pipeline with flush, external stall and bubble count.
// Define PPU_CTRL_HAZARD_EN to enable load-use hazard detection.
module ppu_control_pipe
  import ppu_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int SAT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  ppu_control_pipe_if.slave  bus
);

  ctrl_t            id_ctrl;
  logic             id_illegal;
  ctrl_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic             ex_vld_q, ex_vld_d, mem_vld_q, mem_vld_d, wb_vld_q, wb_vld_d;
  logic             ill_q, ill_d;
  logic [SAT_W-1:0] bubble_q, bubble_d;
  logic             hazard;
  logic             issue;
  logic             bubble;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (&v) ? v : v + SAT_W'(1);
  endfunction

  ppu_ctrl_decode u_decode (
    .instruction (bus.instruction),
    .ctrl        (id_ctrl),
    .illegal     (id_illegal)
  );

`ifdef PPU_CTRL_HAZARD_EN
  // A load in EX whose result the ID instruction needs; suppressed by stall and flush.
  always_comb begin
    hazard = 1'b0;
    if (!bus.stall_in && !bus.flush && bus.instr_valid && ex_vld_q &&
        ex_q.load && (ex_q.dest != 5'd0)) begin
      hazard = (ex_q.dest == bus.instruction[25:21]) ||
               (reads_rt(bus.instruction) && (ex_q.dest == bus.instruction[20:16]));
    end
  end
`else
  assign hazard = 1'b0;
`endif

  always_comb begin
    issue     = bus.instr_valid && !bus.flush && !hazard;
    bubble    = bus.instr_valid && (bus.flush || hazard);
    ex_d      = ex_q;
    ex_vld_d  = ex_vld_q;
    mem_d     = mem_q;
    mem_vld_d = mem_vld_q;
    wb_d      = wb_q;
    wb_vld_d  = wb_vld_q;
    ill_d     = ill_q;
    bubble_d  = bubble_q;
    if (!bus.stall_in) begin
      wb_d      = mem_q;
      wb_vld_d  = mem_vld_q;
      mem_d     = ex_q;
      mem_vld_d = ex_vld_q;
      ex_d      = issue ? id_ctrl : '0;
      ex_vld_d  = issue;
      ill_d     = id_illegal && bus.instr_valid && !bus.flush;
      if (bubble) begin
        bubble_d = sat_inc(bubble_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q      <= '0;
      ex_vld_q  <= 1'b0;
      mem_q     <= '0;
      mem_vld_q <= 1'b0;
      wb_q      <= '0;
      wb_vld_q  <= 1'b0;
      ill_q     <= 1'b0;
      bubble_q  <= '0;
    end else begin
      ex_q      <= ex_d;
      ex_vld_q  <= ex_vld_d;
      mem_q     <= mem_d;
      mem_vld_q <= mem_vld_d;
      wb_q      <= wb_d;
      wb_vld_q  <= wb_vld_d;
      ill_q     <= ill_d;
      bubble_q  <= bubble_d;
    end
  end

  // Stages beyond PIPE_DEPTH read as permanently empty.
  assign bus.id_ctrl       = id_ctrl;
  assign bus.ex_ctrl       = ex_q;
  assign bus.ex_valid      = ex_vld_q;
  assign bus.mem_ctrl      = (PIPE_DEPTH >= 2) ? mem_q : '0;
  assign bus.mem_valid     = (PIPE_DEPTH >= 2) ? mem_vld_q : 1'b0;
  assign bus.wb_ctrl       = (PIPE_DEPTH >= 3) ? wb_q : '0;
  assign bus.wb_valid      = (PIPE_DEPTH >= 3) ? wb_vld_q : 1'b0;
  assign bus.hazard_stall  = hazard;
  assign bus.illegal_instr = ill_q;
  assign bus.bubble_count  = bubble_q;

endmodule

// File: tb/tb_ppu_control_pipe.sv
// Self-checking bench for ppu_control_pipe: decode table plus pipeline scoreboard.
module tb_ppu_control_pipe;
  import ppu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ppu_control_pipe_if #(.SAT_W(16)) bus();

  ppu_control_pipe #(.PIPE_DEPTH(3), .SAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed { ctrl_t ctrl; logic vld; } stage_t;
  typedef struct { logic [31:0] instr; ctrl_t exp; logic ill; string name; } vec_t;

  localparam int NV = 16;
  localparam logic [31:0] I_ADDIU = 32'h24080005;
  localparam logic [31:0] I_LW    = 32'h8D090000;
  localparam logic [31:0] I_ADDU  = 32'h01295021;

  vec_t        vecs [NV];
  stage_t      sb[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_bub = '0;
  logic        exp_ill = 1'b0;
  ctrl_t       c_addiu, c_lw, c_addu;

  // flags = {load, rf_en, branch, jump, mem_rw, mem_se, mem_en}
  function automatic ctrl_t mk(input src_op_e s, input alu_op_e a, input logic [6:0] flags,
                               input logic [1:0] sz, input logic [4:0] d);
    ctrl_t c;
    c = '0;
    c.src_op = s;
    c.alu_op = a;
    {c.load, c.rf_en, c.branch, c.jump, c.mem_rw, c.mem_se, c.mem_en} = flags;
    c.mem_size = sz;
    c.dest = d;
    return c;
  endfunction

  function automatic stage_t st(input ctrl_t c, input logic v);
    stage_t s;
    s.ctrl = c;
    s.vld = v;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic fl, input logic stl);
    bus.instruction = ins;
    bus.instr_valid = v;
    bus.flush = fl;
    bus.stall_in = stl;
  endtask

  task automatic sb_clear();
    sb.delete();
    repeat (3) sb.push_back(st('0, 1'b0));
    exp_bub = '0;
    exp_ill = 1'b0;
  endtask

  task automatic check_pipe(input string tag);
    check({tag, " ex_ctrl"},  32'(bus.ex_ctrl),       32'(sb[2].ctrl));
    check({tag, " ex_vld"},   32'(bus.ex_valid),      32'(sb[2].vld));
    check({tag, " mem_ctrl"}, 32'(bus.mem_ctrl),      32'(sb[1].ctrl));
    check({tag, " mem_vld"},  32'(bus.mem_valid),     32'(sb[1].vld));
    check({tag, " wb_ctrl"},  32'(bus.wb_ctrl),       32'(sb[0].ctrl));
    check({tag, " wb_vld"},   32'(bus.wb_valid),      32'(sb[0].vld));
    check({tag, " illegal"},  32'(bus.illegal_instr), 32'(exp_ill));
    check({tag, " bubbles"},  32'(bus.bubble_count),  32'(exp_bub));
  endtask

  // Unstalled edge: ex_next is what EX should hold afterwards.
  task automatic tick(input string tag, input stage_t ex_next, input logic bub, input logic ill);
    @(posedge clk);
    #1;
    sb.push_back(ex_next);
    void'(sb.pop_front());
    if (bub && (exp_bub != 16'hFFFF)) exp_bub = exp_bub + 16'd1;
    exp_ill = ill;
    check_pipe(tag);
  endtask

  task automatic stall_tick(input string tag);
    @(posedge clk);
    #1;
    check_pipe(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    c_addiu = mk(SRC_IMM, ALU_ADD, 7'b0100000, 2'b00, 5'd8);
    c_lw    = mk(SRC_IMM, ALU_ADD, 7'b1100001, 2'b10, 5'd9);
    c_addu  = mk(SRC_REG, ALU_ADD, 7'b0100000, 2'b00, 5'd10);
    vecs[0]  = '{I_ADDIU,      c_addiu, 1'b0, "addiu"};
    vecs[1]  = '{I_ADDU,       c_addu,  1'b0, "addu"};
    vecs[2]  = '{32'h01495823, mk(SRC_REG,   ALU_SUB, 7'b0100000, 2'b00, 5'd11), 1'b0, "subu"};
    vecs[3]  = '{32'h3C101234, mk(SRC_UPPER, ALU_LUI, 7'b0100000, 2'b00, 5'd16), 1'b0, "lui"};
    vecs[4]  = '{32'h82110004, mk(SRC_IMM,   ALU_ADD, 7'b1100011, 2'b00, 5'd17), 1'b0, "lb"};
    vecs[5]  = '{32'h91120000, mk(SRC_IMM,   ALU_ADD, 7'b1100001, 2'b00, 5'd18), 1'b0, "lbu"};
    vecs[6]  = '{32'h8D130008, mk(SRC_IMM,   ALU_ADD, 7'b1100001, 2'b10, 5'd19), 1'b0, "lw"};
    vecs[7]  = '{32'hA1090000, mk(SRC_IMM,   ALU_ADD, 7'b0000101, 2'b00, 5'd9),  1'b0, "sb"};
    vecs[8]  = '{32'hAD090004, mk(SRC_IMM,   ALU_ADD, 7'b0000101, 2'b10, 5'd9),  1'b0, "sw"};
    vecs[9]  = '{32'h11090004, mk(SRC_REG,   ALU_EQ,  7'b0010000, 2'b00, 5'd9),  1'b0, "beq"};
    vecs[10] = '{32'h1D000002, mk(SRC_REG,   ALU_GTZ, 7'b0010000, 2'b00, 5'd0),  1'b0, "bgtz"};
    vecs[11] = '{32'h0C000100, mk(SRC_PC,    ALU_ADD, 7'b0101000, 2'b00, 5'd31), 1'b0, "jal"};
    vecs[12] = '{32'h03E00008, mk(SRC_REG,   ALU_NOP, 7'b0001000, 2'b00, 5'd0),  1'b0, "jr"};
    vecs[13] = '{32'h00000000, '0, 1'b0, "nop"};
    vecs[14] = '{32'hFC000000, '0, 1'b1, "bad_op"};
    vecs[15] = '{32'h0000002A, '0, 1'b1, "bad_funct"};

    drive(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    sb_clear();
    check_pipe("reset");
    check("reset hazard", 32'(bus.hazard_stall), 32'd0);
    reset = 1'b0;

    // ADDIU reaches EX after one edge and WB two edges later.
    drive(I_ADDIU, 1'b1, 1'b0, 1'b0);
    tick("addiu", st(c_addiu, 1'b1), 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick("addiu+1", st('0, 1'b0), 1'b0, 1'b0);
    tick("addiu+2", st('0, 1'b0), 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].instr, 1'b1, 1'b0, 1'b0);
      #1;
      check({vecs[i].name, " id_ctrl"}, 32'(bus.id_ctrl), 32'(vecs[i].exp));
      check({vecs[i].name, " hazard"}, 32'(bus.hazard_stall), 32'd0);
      tick(vecs[i].name, st(vecs[i].exp, 1'b1), 1'b0, vecs[i].ill);
    end

    // Load-use pair.
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick("lu lw", st(c_lw, 1'b1), 1'b0, 1'b0);
`ifdef PPU_CTRL_HAZARD_EN
    drive(I_ADDU, 1'b1, 1'b0, 1'b1);
    #1;
    check("hazard under stall", 32'(bus.hazard_stall), 32'd0);
    stall_tick("lu stall");
    drive(I_ADDU, 1'b1, 1'b0, 1'b0);
    #1;
    check("hazard raised", 32'(bus.hazard_stall), 32'd1);
    tick("lu bubble", st('0, 1'b0), 1'b1, 1'b0);
    check("hazard one cycle", 32'(bus.hazard_stall), 32'd0);
    tick("lu addu", st(c_addu, 1'b1), 1'b0, 1'b0);
`else
    drive(I_ADDU, 1'b1, 1'b0, 1'b0);
    #1;
    check("hazard disabled", 32'(bus.hazard_stall), 32'd0);
    tick("lu addu", st(c_addu, 1'b1), 1'b0, 1'b0);
`endif

    // Same pair with a flush on the ADDU cycle: ADDU never issues.
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick("fl lw", st(c_lw, 1'b1), 1'b0, 1'b0);
    drive(I_ADDU, 1'b1, 1'b1, 1'b0);
    #1;
    check("flush hazard", 32'(bus.hazard_stall), 32'd0);
    tick("fl bubble", st('0, 1'b0), 1'b1, 1'b0);
    drive(32'hFC000000, 1'b1, 1'b1, 1'b0);
    tick("fl illegal", st('0, 1'b0), 1'b1, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick("fl drain", st('0, 1'b0), 1'b0, 1'b0);

    // External stall for three cycles with LW in MEM.
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick("st lw", st(c_lw, 1'b1), 1'b0, 1'b0);
    drive(32'hFC000000, 1'b1, 1'b0, 1'b0);
    tick("st ill", st('0, 1'b1), 1'b0, 1'b1);
    drive(I_ADDIU, 1'b1, 1'b0, 1'b1);
    stall_tick("stall1");
    stall_tick("stall2");
    drive(I_ADDIU, 1'b1, 1'b1, 1'b1);
    stall_tick("stall3");
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    tick("resume", st('0, 1'b0), 1'b0, 1'b0);

    // Asynchronous reset mid-stream, no clock edge in between.
    drive(I_LW, 1'b1, 1'b0, 1'b0);
    tick("rs lw", st(c_lw, 1'b1), 1'b0, 1'b0);
    drive(32'hFC000000, 1'b1, 1'b1, 1'b0);
    tick("rs flush", st('0, 1'b0), 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sb_clear();
    check_pipe("async reset");
    check("async reset hazard", 32'(bus.hazard_stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(I_ADDIU, 1'b1, 1'b0, 1'b0);
    tick("post reset", st(c_addiu, 1'b1), 1'b0, 1'b0);

    // Saturation of the bubble counter.
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    force dut.bubble_q = 16'hFFFE;
    exp_bub = 16'hFFFE;
    tick("sat preset", st('0, 1'b0), 1'b0, 1'b0);
    release dut.bubble_q;
    drive(I_ADDIU, 1'b1, 1'b1, 1'b0);
    repeat (3) tick("sat bubble", st('0, 1'b0), 1'b1, 1'b0);
    check("sat final", 32'(bus.bubble_count), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ppu_control_pipe.md
PPU_CONTROL_PIPE -- requirements
Module: ppu_control_pipe

Interface
REQ-001 Parameter PIPE_DEPTH, default 3: number of registered control stages (EX, MEM, WB) implemented, legal range 1..3.
REQ-002 Parameter SAT_W, default 16: width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction  input  32  instruction in ID.
REQ-006 instr_valid  input  1  instruction is valid this cycle.
REQ-007 stall_in  input  1  external freeze of all stages.
REQ-008 flush  input  1  squash the ID instruction (branch/jump taken).
REQ-009 id_ctrl  output  CTRL_W  combinational decode of instruction.
REQ-010 ex_ctrl, mem_ctrl, wb_ctrl  output  CTRL_W each  registered stage bundles.
REQ-011 ex_valid, mem_valid, wb_valid  output  1 each  stage holds a real instruction.
REQ-012 hazard_stall  output  1  load-use stall request to fetch/ID.
REQ-013 illegal_instr  output  1  registered; valid ID opcode/funct not in the decode table.
REQ-014 bubble_count  output  SAT_W  saturating count of inserted bubbles.

Function
REQ-015 The bundle SHALL contain src_op[2:0], alu_op[3:0], load, rf_en, branch, jump, mem_size[1:0], mem_rw, mem_se, hi_en, lo_en, mem_en and dest[4:0], with CTRL_W = 23.
REQ-016 Decode SHALL cover ADDU, SUBU, JR (R-type funct), ADDIU, LUI, LB, LBU, LW, SB, SW, BEQ, BGTZ and JAL; every other encoding SHALL decode to an all-zero bundle.
REQ-017 Field values:
- mem_se = 1 for LB only.
- mem_size: 00 byte, 10 word.
- mem_rw = 1 for stores only.
- mem_en = 1 for all loads and stores.
- rf_en = 1 for ADDU, SUBU, ADDIU, LUI, loads and JAL.
- dest: rd for R-type, rt for I-type, 31 for JAL.
REQ-018 Instruction 0x00000000 (NOP) SHALL decode to all-zero with rf_en = 0 and SHALL NOT raise illegal_instr.
REQ-019 When stall_in = 0, each edge SHALL advance WB<=MEM and MEM<=EX.
REQ-020 When stall_in = 0, EX SHALL load the ID bundle with valid = 1 if instr_valid = 1, flush = 0 and hazard_stall = 0; otherwise EX SHALL load an all-zero bubble with valid = 0.
REQ-021 When stall_in = 1, every stage register, illegal_instr and bubble_count SHALL hold, and hazard_stall SHALL read 0.
REQ-022 flush SHALL be sampled only when stall_in = 0; a flush SHALL override a simultaneous hazard, forcing hazard_stall = 0.
REQ-023 Each bubble inserted while instr_valid = 1 (hazard or flush) SHALL increment bubble_count by 1, saturating at all-ones without wrapping.
REQ-024 illegal_instr SHALL register the decode miss of the ID instruction each unstalled edge, qualified by instr_valid and not flush.
REQ-025 Stage outputs above PIPE_DEPTH SHALL be tied to zero and their valids to 0; the latency from ID to ex_ctrl SHALL be 1 cycle.

Reset
REQ-026 On reset, all stage bundles, valids, illegal_instr and bubble_count SHALL clear to 0 immediately without waiting for clk, and hazard_stall SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight bundles; the first unstalled edge after release SHALL load EX from ID.

Configuration
REQ-028 With PPU_CTRL_HAZARD_EN defined, hazard_stall SHALL be asserted combinationally when all of the following hold:
- ex_valid = 1;
- ex_ctrl.load = 1;
- ex_ctrl.dest != 0;
- ex_ctrl.dest equals the ID instruction's rs, or equals rt for an instruction that reads rt;
- instr_valid = 1.
REQ-029 Without PPU_CTRL_HAZARD_EN, hazard_stall SHALL be constant 0 and no bubble SHALL result from a hazard.

Structure
REQ-030 The opcode/funct constants, the alu_op encodings, CTRL_W and the bundle typedef SHALL live in the shared package ppu_ctrl_pkg.
REQ-031 Decode SHALL be a combinational sub-module ppu_ctrl_decode (instruction -> bundle, illegal), instantiated once.

Verification
REQ-032 Scenario: reset, then 0x24080005 (ADDIU $t0,$0,5) -> after 1 edge, ex_valid = 1, src_op = 001, alu_op = ADD, rf_en = 1, dest = 8; wb_valid = 1 two edges later.
REQ-033 Scenario (macro on): 0x8D090000 (LW $t1,0($t0)) followed by 0x01295021 (ADDU $t2,$t1,$t1) -> hazard_stall = 1 for exactly one cycle; EX then holds a bubble; bubble_count = 1; ADDU reaches EX on the following edge.
REQ-034 Scenario: the same pair with flush = 1 on the ADDU cycle -> hazard_stall = 0; EX holds a bubble; ADDU is never issued.
REQ-035 Scenario: stall_in = 1 for 3 cycles with LW in MEM -> mem_ctrl and wb_ctrl are unchanged during the stall and resume advancing once stall_in returns to 0.
REQ-036 Scenario: 0xFC000000 valid -> illegal_instr = 1 after 1 edge and id_ctrl = 0; reset asserted mid-stream -> all outputs 0 with no clk edge.
REQ-037 Scenario: force bubble_count to all-ones minus 1 and insert 3 bubbles -> bubble_count = 0xFFFF (SAT_W = 16).
